// File: rtl/alu_writeback_if.sv
// Operation channel into the LC-3 execute/writeback stage and the register-file
// write port it drives back.
interface alu_writeback_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
);
  // Handshake: an operation moves when in_valid && in_ready are both high at a
  // rising clock edge. The operand fields only need to be valid in that cycle.
  // in_valid is ignored while in_ready is low. rf_load is a one-cycle write strobe.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sr1_data;
  logic [WIDTH-1:0] sr2_data;
  logic [IMM_W-1:0] imm;
  logic             use_imm;
  logic [2:0]       aluk;
  logic [2:0]       dr;
  logic             set_cc;
  logic [WIDTH-1:0] rf_q;
  logic [2:0]       rf_dr;
  logic             rf_load;

  modport master (
    output in_valid, sr1_data, sr2_data, imm, use_imm, aluk, dr, set_cc,
    input  in_ready, rf_q, rf_dr, rf_load
  );

  modport slave (
    input  in_valid, sr1_data, sr2_data, imm, use_imm, aluk, dr, set_cc,
    output in_ready, rf_q, rf_dr, rf_load
  );
endinterface

// File: rtl/alu_writeback.sv
// LC-3 execute/writeback stage: latches an ALU op, computes it, then writes the
// register file for one cycle and updates NZP. Define ALU_MUL_EN for the 16-cycle multiply.
module alu_writeback #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_writeback_if.slave bus,
  output logic [2:0]     nzp,
  output logic           busy,
  output logic [1:0]     state_dbg
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2, MUL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       aluk_q;
  logic [2:0]       dr_q;
  logic             set_cc_q;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] wb_val;
  logic             transfer;
  logic             wb_go;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [3:0]       cnt;
`endif

  assign transfer  = bus.in_valid && bus.in_ready;
  assign b_in      = bus.use_imm ? {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : bus.sr2_data;
  assign state_dbg = state;

  always_comb begin
    alu_out = a_q;
    case (aluk_q)
      3'b000:  alu_out = a_q + b_q;
      3'b001:  alu_out = a_q & b_q;
      3'b010:  alu_out = ~a_q;
      default: alu_out = a_q;
    endcase
  end

  // wb_go marks the edge that enters WB; rf_q, rf_dr and nzp all load there.
  always_comb begin
`ifdef ALU_MUL_EN
    acc_step = acc + (b_q[0] ? a_q : '0);
    wb_go    = ((state == EXEC) && (aluk_q != 3'b100)) || ((state == MUL) && (cnt == 4'hF));
    wb_val   = (state == MUL) ? acc_step : alu_out;
`else
    wb_go    = (state == EXEC);
    wb_val   = alu_out;
`endif
  end

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
    if (r[WIDTH-1])     return 3'b100;
    else if (r == '0)   return 3'b010;
    else                return 3'b001;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      aluk_q       <= '0;
      dr_q         <= '0;
      set_cc_q     <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.rf_q     <= '0;
      bus.rf_dr    <= '0;
      bus.rf_load  <= 1'b0;
      nzp          <= 3'b010;
      busy         <= 1'b0;
`ifdef ALU_MUL_EN
      acc          <= '0;
      cnt          <= '0;
`endif
    end else begin
      bus.rf_load <= 1'b0;
      case (state)
        IDLE, WB: begin
          if (transfer) begin
            a_q          <= bus.sr1_data;
            b_q          <= b_in;
            aluk_q       <= bus.aluk;
            dr_q         <= bus.dr;
            set_cc_q     <= bus.set_cc;
            state        <= EXEC;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end else begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
          end
        end
        EXEC: begin
`ifdef ALU_MUL_EN
          if (aluk_q == 3'b100) begin
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
`endif
        end
`ifdef ALU_MUL_EN
        // Shift-add: one multiplier bit (b_q LSB) per cycle, multiplicand shifts left.
        MUL: begin
          acc <= acc_step;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + 4'd1;
        end
`endif
        default: state <= IDLE;
      endcase

      if (wb_go) begin
        state        <= WB;
        bus.rf_q     <= wb_val;
        bus.rf_dr    <= dr_q;
        bus.rf_load  <= 1'b1;
        bus.in_ready <= 1'b1;
        if (set_cc_q) nzp <= nzp_of(wb_val);
      end
    end
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Execute/writeback stage of the LC-3 datapath, sitting directly downstream of the 8×16 register file read ports and feeding back into its write port. Accepts SR1/SR2 operands (or sign-extended imm5) plus an ALU opcode through a valid/ready handshake. Computes the result over one or more cycles, then issues a single-cycle register-file write (Q/DR/load) and updates the NZP condition codes.

## Interface
Parameters:
- WIDTH, 16, datapath width; the block is only specified for 16.
- IMM_W, 5, immediate field width, sign-extended to WIDTH.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; all state is cleared while low.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
- sr1_data  in  WIDTH  operand A, from register file SR1_OUT.
- sr2_data  in  WIDTH  operand B, from register file SR2_OUT.
- imm  in  IMM_W  immediate, two's complement.
- use_imm  in  1  1: B = sign-extended imm; 0: B = sr2_data.
- aluk  in  3  000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 MUL (see Configuration), 101–111 PASS A.
- dr  in  3  destination register index.
- set_cc  in  1  update NZP on writeback.
- rf_q  out  WIDTH  write data to register file Q.
- rf_dr  out  3  write index to register file DR.
- rf_load  out  1  write strobe to register file load.
- nzp  out  3  condition codes {N,Z,P}.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, MUL (present only with the macro), WB.
- IDLE: in_ready=1. On a transfer, latch A, B (sign-extended imm when use_imm), aluk, dr and set_cc, then go to EXEC.
- EXEC: compute result into the result register. ADD wraps mod 2^16; AND is bitwise; NOT inverts A; PASS returns A. Next state is WB, or MUL for aluk=100 with the macro enabled.
- WB: rf_load=1 for exactly this cycle, with rf_q=result and rf_dr=latched dr. If set_cc, nzp takes 100 when result[15]=1, 010 when result is 0, and 001 otherwise, at the WB edge. in_ready=1 in WB. A transfer in WB goes to EXEC; with no transfer the FSM returns to IDLE.
- An op accepted during WB reads pre-write register values. Upstream must not issue an op dependent on the one currently in WB; the block does no forwarding.
- rf_q and rf_dr hold their last value outside WB; rf_load is 0 outside WB.
- in_valid outside in_ready is ignored. The block does not require upstream to hold its inputs.

## Timing
- Reset values: in_ready=1, rf_load=0, rf_q=0, rf_dr=0, nzp=010, busy=0, state=IDLE.
- Non-MUL op: accepted at edge k, EXEC during cycle k+1, WB during cycle k+2. The register file writes at the end of k+2.
- Throughput: one non-MUL op per 2 cycles with back-to-back accepts in WB.
- MUL: EXEC for 1 cycle, MUL for 16 cycles, then WB. The WB cycle is k+18; in_ready=0 from k+1 through k+17.
- Reset asserted mid-operation drops the pending op with no rf_load and no nzp change; state returns immediately to reset values.

## Configuration
- ALU_MUL_EN defined: aluk=100 runs an iterative shift-add multiply. A 4-bit counter covers 16 cycles, one multiplier bit per cycle. Result = low 16 bits of A×B, unsigned, which equals the two's-complement low half.
- ALU_MUL_EN undefined: the MUL state and counter are absent, and aluk=100 behaves as PASS A with non-MUL latency.

## Test plan
- ADD imm: sr1=0x0003, imm=5'b11011 (−5), use_imm=1, dr=2, set_cc=1 -> WB at k+2: rf_q=0xFFFE, rf_dr=2, rf_load=1 for 1 cycle, nzp=100.
- AND to zero: sr1=0x00F0, sr2=0x0F0F, set_cc=1 -> rf_q=0x0000, nzp=010. Then NOT with sr1=0x00FF, set_cc=0 -> rf_q=0xFF00, nzp stays 010.
- Back-to-back: second op held valid during first WB -> accepted in WB; rf_load pulses at cycles k+2 and k+4 with the correct distinct dr values.
- With ALU_MUL_EN: sr1=0x0012, sr2=0x0034, aluk=100 -> in_ready=0 for 17 cycles, rf_q=0x03A8 at k+18, nzp=001. Without the macro the same stimulus gives rf_q=0x0012 at k+2.
- Reset low during the MUL state (cycle k+8) -> no rf_load, nzp=010, in_ready=1, busy=0 immediately. The next op then completes normally.
- Reset values checked before the first clock edge, and in_valid asserted during EXEC is ignored with no extra WB.
